// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, fetch granularity and the
// {pc, instr} record carried through the instruction buffer.
package core_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush.
// The head is presented straight from storage; there is no write-to-read bypass.
module fetch_buffer
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output logic               head_valid,
    output fetch_entry_t       head_data,
    output logic [CNT_W-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_valid = (count_q != '0);
    assign push_ok    = push && (count_q != CNT_W'(DEPTH));
    assign pop_ok     = pop && head_valid;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: issues sequential word fetches, tracks the single
// in-flight response and queues returned words for decode; redirects squash all.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_stall,
    input  logic [XLEN-1:0] imem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;
    logic             deq;
    logic             issue_en;
    logic             push;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign deq = if_valid & id_ready;

    // Slots already committed after this cycle's dequeue; a new fetch needs a free one.
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(deq);
    assign issue_en  = ~rst & ~redirect_valid & (occupancy < (CNT_W + 1)'(DEPTH));

    assign imem_stall = ~issue_en;
    assign imem_addr  = pc_q;

    assign push       = inflight_q & ~redirect_valid & ~rst;
    assign push_entry = '{pc: inflight_pc_q, instr: imem_data};

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue_en;
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (issue_en) begin
            pc_d          = pc_q + XLEN'(INSTR_BYTES);
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  (push_entry),
        .pop        (deq),
        .head_valid (if_valid),
        .head_data  (head),
        .count      (count)
    );

    assign if_instr = head.instr;
    assign if_pc    = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios followed by randomized
// backpressure/redirect/reset traffic, checked by a PC-stream scoreboard.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_stall;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;

    logic [31:0] exp_q[$];
    logic [31:0] next_pc = RESET_PC;
    logic [31:0] exp_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_stall     (imem_stall),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0010_0093;
            32'h8:   return 32'h0020_0113;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    // Synchronous instruction memory: data follows an un-stalled address by one cycle.
    initial imem_data = 32'h0;
    always @(posedge clk) begin
        if (imem_stall === 1'b0) imem_data <= mem_word(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: the expected stream is consecutive words from the last
    // reset/redirect target; every accepted head must be the next one in it.
    always @(negedge clk) begin
        if (rst === 1'b0 && if_valid === 1'b1 && id_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                exp_q.push_back(next_pc);
                next_pc = next_pc + 32'd4;
            end
            exp_pc = exp_q.pop_front();
            chk("accept_pc", if_pc, exp_pc);
            chk("accept_instr", if_instr, mem_word(exp_pc));
            $display("accept pc=0x%08h instr=0x%08h exp_pc=0x%08h", if_pc, if_instr, exp_pc);
            n_acc++;
        end
        if (if_valid === 1'b0) begin
            chk("empty_pc_zero", if_pc, 32'h0);
            chk("empty_instr_zero", if_instr, 32'h0);
        end
        if (rst === 1'b1 || redirect_valid === 1'b1)
            chk("stall_on_flush", {31'h0, imem_stall}, 32'h1);
        if (rst === 1'b1) begin
            exp_q.delete();
            next_pc = RESET_PC;
        end else if (redirect_valid === 1'b1) begin
            exp_q.delete();
            next_pc = {redirect_pc[31:2], 2'b00};
        end
    end

    task automatic drive(input logic r, input logic rv, input logic [31:0] tgt, input logic rdy);
        @(posedge clk);
        #1;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = tgt;
        id_ready       = rdy;
        @(negedge clk);
    endtask

    task automatic chk_head(input string name, input logic [31:0] pc);
        chk({name, "_valid"}, {31'h0, if_valid}, 32'h1);
        chk({name, "_pc"}, if_pc, pc);
        chk({name, "_instr"}, if_instr, mem_word(pc));
    endtask

    initial begin
        logic        r, rv, rdy;
        logic [31:0] tgt;

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 1);

        // Cold start: fetch in the first cycle out of reset, head two cycles later.
        drive(0, 0, 0, 1);
        chk("c0_addr", imem_addr, 32'h0);
        chk("c0_stall", {31'h0, imem_stall}, 32'h0);
        chk("c0_valid", {31'h0, if_valid}, 32'h0);
        drive(0, 0, 0, 1);
        chk("c1_addr", imem_addr, 32'h4);
        chk("c1_valid", {31'h0, if_valid}, 32'h0);
        drive(0, 0, 0, 1);
        chk("c2_addr", imem_addr, 32'h8);
        chk_head("c2", 32'h0);

        // Backpressure: buffer fills, fetch stalls with the address frozen.
        drive(0, 0, 0, 0);
        chk_head("c3", 32'h4);
        for (int i = 4; i <= 7; i++) drive(0, 0, 0, 0);
        chk("bp_stall", {31'h0, imem_stall}, 32'h1);
        chk("bp_addr", imem_addr, 32'hC);
        drive(0, 0, 0, 1);
        chk_head("c8", 32'h4);
        drive(0, 0, 0, 1);
        chk_head("c9", 32'h8);
        drive(0, 0, 0, 1);
        chk_head("c10", 32'hC);

        // Redirect to 0x100 with a full buffer.
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
        drive(0, 1, 32'h100, 1);
        drive(0, 0, 0, 1);
        chk("rd1_valid_t1", {31'h0, if_valid}, 32'h0);
        chk("rd1_addr_t1", imem_addr, 32'h100);
        drive(0, 0, 0, 1);
        chk("rd1_valid_t2", {31'h0, if_valid}, 32'h0);
        drive(0, 0, 0, 1);
        chk_head("rd1_t3", 32'h100);

        // Misaligned target: low bits dropped.
        drive(0, 1, 32'h102, 1);
        drive(0, 0, 0, 1);
        chk("rd2_addr_t1", imem_addr, 32'h100);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        chk_head("rd2_t3", 32'h100);

        // Top-of-memory target: PC wraps to zero.
        drive(0, 1, 32'hFFFF_FFFC, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        chk_head("wrap_t3", 32'hFFFF_FFFC);
        drive(0, 0, 0, 1);
        chk_head("wrap_t4", 32'h0);

        // Mid-stream reset with a full buffer.
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("rst_stall", {31'h0, imem_stall}, 32'h1);
        drive(0, 0, 0, 1);
        chk("rst_c0_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_c0_addr", imem_addr, RESET_PC);
        drive(0, 0, 0, 1);
        chk("rst_c1_valid", {31'h0, if_valid}, 32'h0);
        drive(0, 0, 0, 1);
        chk_head("rst_c2", RESET_PC);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            rv  = !r && ($urandom_range(0, 24) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            rdy = !r && ($urandom_range(0, 3) != 0);
            drive(r, rv, tgt, rdy);
        end
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        chk("throughput_min", (n_acc >= 1000) ? 32'h1 : 32'h0, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
